// File: rtl/mux_scan_reg.sv
//------------------------------------------------------------------------------
// mux_scan_reg : registered NCH-channel word mux with manual / auto-scan modes
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux_scan_reg #(
  parameter int NBITS = 8,
  parameter int NCH   = 4,
  parameter int DWELL = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk_2,
  input  logic                 reset_n,
  input  logic [NCH*NBITS-1:0] din,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic                 hold,
  output logic [NBITS-1:0]     dout,
  output logic [SELW-1:0]      ch,
  output logic                 valid,
  output logic                 wrap,
  output logic                 err
);

  localparam int              CNTW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW-1:0] C_LAST_CH  = SELW'(NCH - 1);
  localparam logic [CNTW-1:0] C_LAST_CNT = CNTW'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [NBITS-1:0] words [NCH];
  logic [SELW-1:0]  next_ch;
  logic [NBITS-1:0] sel_word, cur_word, next_word;
  logic             sel_ok;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign words[k] = din[k*NBITS +: NBITS];
  end

  assign next_ch = (ch_q == C_LAST_CH) ? '0 : ch_q + 1'b1;

  // Range check falls out of the decode: a select with no matching channel is out of range.
  always_comb begin
    sel_ok    = 1'b0;
    sel_word  = '0;
    cur_word  = '0;
    next_word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k)) begin
        sel_ok   = 1'b1;
        sel_word = words[k];
      end
      if (ch_q == SELW'(k))    cur_word  = words[k];
      if (next_ch == SELW'(k)) next_word = words[k];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    err_d   = err_q;
    wrap_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      state_d = mode ? ST_SCAN : ST_MANUAL;
      cnt_d   = '0;
      ch_d    = '0;
      dout_d  = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (!hold) begin
      if (!mode) begin
        state_d = ST_MANUAL;
        cnt_d   = '0;
        if (sel_ok) begin
          ch_d    = sel;
          dout_d  = sel_word;
          valid_d = 1'b1;
          err_d   = 1'b0;
        end else begin
          dout_d  = '0;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end
      end else if (state_q != ST_SCAN) begin
        // Entering scan keeps the current channel and restarts its dwell.
        state_d = ST_SCAN;
        cnt_d   = '0;
        dout_d  = cur_word;
        valid_d = 1'b1;
        err_d   = 1'b0;
      end else if (cnt_q == C_LAST_CNT) begin
        cnt_d   = '0;
        ch_d    = next_ch;
        dout_d  = next_word;
        wrap_d  = (ch_q == C_LAST_CH);
        valid_d = 1'b1;
        err_d   = 1'b0;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        dout_d  = cur_word;
        valid_d = 1'b1;
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign dout  = dout_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_reg.sv
//------------------------------------------------------------------------------
// tb_mux_scan_reg : scoreboard bench for mux_scan_reg (NCH=4/3, DWELL=4/1)
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mux_scan_reg;

  logic        clk_2 = 1'b0;
  logic        reset_n;
  logic [31:0] din;
  logic        mode;
  logic [1:0]  sel;
  logic        hold;

  logic [7:0] a_dout, b_dout, c_dout;
  logic [1:0] a_ch, b_ch, c_ch;
  logic       a_valid, b_valid, c_valid;
  logic       a_wrap, b_wrap, c_wrap;
  logic       a_err, b_err, c_err;

  always #5 clk_2 = ~clk_2;

  mux_scan_reg #(.NBITS(8), .NCH(4), .DWELL(4)) u_a (
    .clk_2(clk_2), .reset_n(reset_n), .din(din), .mode(mode), .sel(sel), .hold(hold),
    .dout(a_dout), .ch(a_ch), .valid(a_valid), .wrap(a_wrap), .err(a_err));

  mux_scan_reg #(.NBITS(8), .NCH(3), .DWELL(4)) u_b (
    .clk_2(clk_2), .reset_n(reset_n), .din(din[23:0]), .mode(mode), .sel(sel), .hold(hold),
    .dout(b_dout), .ch(b_ch), .valid(b_valid), .wrap(b_wrap), .err(b_err));

  mux_scan_reg #(.NBITS(8), .NCH(4), .DWELL(1)) u_c (
    .clk_2(clk_2), .reset_n(reset_n), .din(din), .mode(mode), .sel(sel), .hold(hold),
    .dout(c_dout), .ch(c_ch), .valid(c_valid), .wrap(c_wrap), .err(c_err));

  typedef struct packed {
    logic [7:0] dout;
    logic [1:0] ch;
    logic       valid;
    logic       wrap;
    logic       err;
  } obs_t;

  obs_t exp_a[$];
  obs_t exp_b[$];
  obs_t exp_c[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic obs_t mk(logic [7:0] d, logic [1:0] c, logic v, logic w, logic e);
    mk = '{dout: d, ch: c, valid: v, wrap: w, err: e};
  endfunction

  function automatic obs_t got_a();
    got_a = '{dout: a_dout, ch: a_ch, valid: a_valid, wrap: a_wrap, err: a_err};
  endfunction

  function automatic obs_t got_b();
    got_b = '{dout: b_dout, ch: b_ch, valid: b_valid, wrap: b_wrap, err: b_err};
  endfunction

  function automatic obs_t got_c();
    got_c = '{dout: c_dout, ch: c_ch, valid: c_valid, wrap: c_wrap, err: c_err};
  endfunction

  function automatic logic [7:0] byte_of(int k);
    byte_of = din[k*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset(input logic m, input logic [1:0] s);
    hold    = 1'b0;
    mode    = m;
    sel     = s;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, g;
    din = 32'h44332211; mode = 1'b0; sel = 2'd1; hold = 1'b0;
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    exp_a.push_back(mk(8'h22, 2'd1, 1'b1, 1'b0, 1'b0));
    tick();
    e = exp_a.pop_front(); g = got_a(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL pre_reset: got %h expected %h", g, e); end
    #3 reset_n = 1'b0;
    #1;
    e = mk(8'h00, 2'd0, 1'b0, 1'b0, 1'b0); g = got_a(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL reset_async: got %h expected %h", g, e); end
    sel = 2'd2;
    #2 reset_n = 1'b1;
    exp_a.push_back(mk(8'h00, 2'd0, 1'b0, 1'b0, 1'b0));
    exp_a.push_back(mk(8'h33, 2'd2, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_a.pop_front(); g = got_a(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL reset_idle_step%0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_manual_latency();
    obs_t e, g;
    sel = 2'd0;
    exp_a.push_back(mk(8'h11, 2'd0, 1'b1, 1'b0, 1'b0));
    tick();
    e = exp_a.pop_front(); g = got_a(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL manual_sel: got %h expected %h", g, e); end
    din[7:0] = 8'hA5;
    #1;
    n_checks++;
    if (a_dout !== 8'h11) begin n_fail++; $display("FAIL manual_no_comb: got %h expected 11", a_dout); end
    exp_a.push_back(mk(8'hA5, 2'd0, 1'b1, 1'b0, 1'b0));
    tick();
    e = exp_a.pop_front(); g = got_a(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL manual_din: got %h expected %h", g, e); end
  endtask

  task automatic test_out_of_range();
    obs_t e, g;
    logic [1:0] sels [4] = '{2'd2, 2'd2, 2'd3, 2'd1};
    din = 32'h44332211;
    do_reset(1'b0, 2'd2);
    exp_a.push_back(mk(8'h00, 2'd0, 1'b0, 1'b0, 1'b0));
    exp_b.push_back(mk(8'h00, 2'd0, 1'b0, 1'b0, 1'b0));
    exp_a.push_back(mk(8'h33, 2'd2, 1'b1, 1'b0, 1'b0));
    exp_b.push_back(mk(8'h33, 2'd2, 1'b1, 1'b0, 1'b0));
    exp_a.push_back(mk(8'h44, 2'd3, 1'b1, 1'b0, 1'b0));
    exp_b.push_back(mk(8'h00, 2'd2, 1'b0, 1'b0, 1'b1));
    exp_a.push_back(mk(8'h22, 2'd1, 1'b1, 1'b0, 1'b0));
    exp_b.push_back(mk(8'h22, 2'd1, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      sel = sels[i];
      tick();
      e = exp_a.pop_front(); g = got_a(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL range_a_step%0d: got %h expected %h", i, g, e); end
      e = exp_b.pop_front(); g = got_b(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL range_b_step%0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_scan();
    obs_t e, g;
    int ca, cb, cc;
    logic v;
    din = 32'h44332211;
    do_reset(1'b1, 2'd0);
    for (int j = 0; j <= 16; j++) begin
      v  = (j > 0);
      ca = (j / 4) % 4;
      cb = (j / 4) % 3;
      cc = j % 4;
      exp_a.push_back(mk(v ? byte_of(ca) : 8'h00, 2'(ca), v, v && (j % 16 == 0), 1'b0));
      exp_b.push_back(mk(v ? byte_of(cb) : 8'h00, 2'(cb), v, v && (j % 12 == 0), 1'b0));
      exp_c.push_back(mk(v ? byte_of(cc) : 8'h00, 2'(cc), v, v && (j % 4 == 0), 1'b0));
    end
    for (int j = 0; j <= 16; j++) begin
      tick();
      e = exp_a.pop_front(); g = got_a(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL scan_a_cyc%0d: got %h expected %h", j, g, e); end
      e = exp_b.pop_front(); g = got_b(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL scan_b_cyc%0d: got %h expected %h", j, g, e); end
      e = exp_c.pop_front(); g = got_c(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL scan_c_cyc%0d: got %h expected %h", j, g, e); end
    end
    // Freeze right after a wrap: wrap must drop while everything else holds.
    hold = 1'b1;
    exp_a.push_back(mk(8'h11, 2'd0, 1'b1, 1'b0, 1'b0));
    exp_b.push_back(mk(8'h22, 2'd1, 1'b1, 1'b0, 1'b0));
    exp_c.push_back(mk(8'h11, 2'd0, 1'b1, 1'b0, 1'b0));
    tick();
    e = exp_a.pop_front(); g = got_a(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL hold_wrap_a: got %h expected %h", g, e); end
    e = exp_b.pop_front(); g = got_b(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL hold_wrap_b: got %h expected %h", g, e); end
    e = exp_c.pop_front(); g = got_c(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL hold_wrap_c: got %h expected %h", g, e); end
    hold = 1'b0;
  endtask

  task automatic test_hold();
    obs_t e, g;
    din = 32'h44332211;
    do_reset(1'b1, 2'd0);
    for (int j = 0; j < 7; j++) tick();
    e = mk(8'h22, 2'd1, 1'b1, 1'b0, 1'b0); g = got_a(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL hold_setup: got %h expected %h", g, e); end
    hold = 1'b1;
    din[15:8] = 8'h5A;
    for (int i = 0; i < 5; i++) exp_a.push_back(mk(8'h22, 2'd1, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin mode = 1'b0; sel = 2'd3; end
      tick();
      e = exp_a.pop_front(); g = got_a(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL hold_frozen%0d: got %h expected %h", i, g, e); end
    end
    mode = 1'b1;
    hold = 1'b0;
    exp_a.push_back(mk(8'h5A, 2'd1, 1'b1, 1'b0, 1'b0));
    exp_a.push_back(mk(8'h33, 2'd2, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_a.pop_front(); g = got_a(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL hold_release%0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_mode_switch();
    obs_t e, g;
    din = 32'h44332211;
    do_reset(1'b1, 2'd0);
    for (int j = 0; j < 13; j++) tick();
    e = mk(8'h44, 2'd3, 1'b1, 1'b0, 1'b0); g = got_a(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL mode_setup: got %h expected %h", g, e); end
    mode = 1'b0;
    sel  = 2'd1;
    exp_a.push_back(mk(8'h22, 2'd1, 1'b1, 1'b0, 1'b0));
    tick();
    e = exp_a.pop_front(); g = got_a(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL mode_to_manual: got %h expected %h", g, e); end
    mode = 1'b1;
    for (int i = 0; i < 4; i++) exp_a.push_back(mk(8'h22, 2'd1, 1'b1, 1'b0, 1'b0));
    exp_a.push_back(mk(8'h33, 2'd2, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      tick();
      e = exp_a.pop_front(); g = got_a(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL mode_to_scan%0d: got %h expected %h", i, g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_manual_latency();
    test_out_of_range();
    test_scan();
    test_hold();
    test_mode_switch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
- Parametrised, registered N-channel word multiplexer.
- Successor to the switch-driven combinational LED selector: generalised to NCH channels of NBITS bits.
- Adds a manual/auto-scan mode, a dwell counter, hold/freeze, a wrap pulse and an out-of-range flag.
- Sits between switch/data sources and the LED/LCD debug outputs of top; all outputs are registered on clk_2.

Parameters:
- NBITS, 8, width of each channel word
- NCH, 4, number of input channels (≥2, need not be a power of 2)
- DWELL, 4, clk_2 cycles each channel is shown in scan mode (≥1)
- SELW, $clog2(NCH), select/channel-index width (derived, not overridden)

Ports:
- clk_2  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- din  input  NCH*NBITS  flattened channel words; channel k = din[k*NBITS +: NBITS]
- mode  input  1  0 = manual (use sel), 1 = auto-scan
- sel  input  SELW  manual channel select
- hold  input  1  freeze all state and outputs while 1
- dout  output  NBITS  registered selected word
- ch  output  SELW  registered index of the channel currently driven on dout
- valid  output  1  dout is meaningful
- wrap  output  1  one-cycle pulse when scan advances from NCH-1 to 0
- err  output  1  manual sel ≥ NCH

Behaviour:
- Clock and reset
  - One clock (clk_2).
  - reset_n is asynchronous and active-low; asserting it at any time, including mid-scan, forces the reset state immediately.
- Reset values
  - dout=0, ch=0, valid=0, wrap=0, err=0.
  - Dwell counter cnt=0.
  - FSM state = IDLE.
- FSM states
  - IDLE
    - Entered from reset; lasts exactly one cycle.
    - Exits to MANUAL if mode=0, else to SCAN.
    - valid stays 0 during IDLE.
  - MANUAL
    - Each cycle: ch<=sel and dout<=din[sel].
    - Latency is 1 cycle from sel/din to dout.
    - If sel ≥ NCH: dout<=0, ch<=ch (unchanged), err<=1, valid<=0.
    - Otherwise: err<=0, valid<=1.
    - Transitions to SCAN on the first cycle mode=1 is sampled.
  - SCAN
    - dout<=din[ch] every cycle, so din changes track with 1-cycle latency even mid-dwell.
    - cnt counts 0..DWELL-1.
    - When cnt=DWELL-1: cnt<=0 and ch<=ch+1, wrapping NCH-1 → 0.
    - In that same cycle dout<=din[next ch], and wrap<=1 only on the NCH-1 → 0 step.
    - valid=1, err=0.
    - Transitions to MANUAL on the first cycle mode=0 is sampled.
- Mode switching
  - MANUAL→SCAN: scan starts from the current ch with cnt=0.
  - SCAN→MANUAL: ch/dout take sel in that same edge, with the MANUAL rules applied.
- hold
  - While hold=1 in MANUAL or SCAN: state, cnt, ch, dout, valid and err keep their values; wrap=0.
  - hold is ignored in IDLE.
  - hold has priority over mode changes: a mode change is acted on only after hold drops.
- DWELL=1: ch advances every cycle.
- Ordering
  - wrap is registered alongside ch; it is high in the cycle where ch first reads 0.
- Simultaneous events
  - reset_n low overrides everything.
  - hold beats a dwell expiry: cnt does not advance, so the expiry is deferred, not lost.

Test Plan:
- Reset/IDLE
  - Stimulus: NBITS=8, NCH=4; assert reset_n=0 mid-operation, release with mode=0, sel=2, din={8'h44,8'h33,8'h22,8'h11}.
  - Required: all outputs 0 immediately; valid=0 for the IDLE cycle; next edge dout=8'h33, ch=2, valid=1.
- Manual latency
  - Stimulus: change sel 2→0 at cycle n.
  - Required: dout=8'h11, ch=0 at edge n+1; a din[0] change to 8'hA5 appears on dout one cycle later.
- Out-of-range
  - Stimulus: NCH=3 (SELW=2), mode=0, sel=3.
  - Required: next edge dout=0, err=1, valid=0, ch holds its previous value; sel=1 → err=0, dout=din[1].
- Scan and wrap
  - Stimulus: DWELL=4, NCH=4, mode=1 from ch=0.
  - Required: ch sequence 0,0,0,0,1,1,1,1,2,…,3,3,3,3,0; wrap=1 only in the first cycle ch=0 after 3; period 16 cycles.
- Hold
  - Stimulus: during scan at ch=1, cnt=2, assert hold for 5 cycles while din[1] changes.
  - Required: dout, ch and cnt frozen; wrap=0; after release, ch advances to 2 exactly 2 cycles later.
- Mode switch
  - Stimulus: scanning at ch=3, set mode=0 with sel=1.
  - Required: next edge ch=1, dout=din[1]; set mode=1 again → scan continues 1,1,1,1,2 with cnt restarted at 0.
